friscv_icache_line_fill: RTL

Instruction-cache line-fill engine, directly upstream of the cache-line storage write port. On a cache miss it fetches one full cache line from memory over an AXI4 read burst and assembles the beats into a line. It then writes the line to the cache storage in a single cycle (`cache_wen`/`cache_waddr`/`cache_wdata`) and reports completion to the fetch control.

---
 rtl/friscv_icache_line_fill.sv | 133 +++++++++++++
 1 files changed

// File: rtl/friscv_icache_line_fill.sv
// I-cache line fill: one AXI4 INCR burst per miss, beats assembled into a line, written in one cycle.
// Latency BEATS+3 cycles request-to-next-accept; stalls on arready/rvalid, one fill outstanding.
module friscv_icache_line_fill #(
  parameter int ADDR_W       = 32,
  parameter int AXI_DATA_W   = 32,
  parameter int AXI_ID_W     = 8,
  parameter logic [AXI_ID_W-1:0] AXI_ID = 'h10,
  parameter int CACHE_LINE_W = 128
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    srst,
  input  logic                    miss_valid,
  output logic                    miss_ready,
  input  logic [ADDR_W-1:0]       miss_addr,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_W-1:0]       araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [AXI_ID_W-1:0]     arid,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [AXI_DATA_W-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  output logic                    cache_wen,
  output logic [ADDR_W-1:0]       cache_waddr,
  output logic [CACHE_LINE_W-1:0] cache_wdata,
  output logic                    fill_done,
  output logic                    fill_error
);

  localparam int BEATS      = CACHE_LINE_W / AXI_DATA_W;
  localparam int LINE_BYTES = CACHE_LINE_W / 8;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, AR, R, WR} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        beat_cnt;
  logic                    err;
  logic [CACHE_LINE_W-1:0] line;
  logic                    is_last;
  logic                    beat_bad;
  logic                    err_next;

  assign arlen       = 8'(BEATS - 1);
  assign arsize      = 3'($clog2(AXI_DATA_W / 8));
  assign arburst     = 2'b01;
  assign arid        = AXI_ID;
  assign cache_waddr = araddr;
  assign cache_wdata = line;

  // rlast is only a consistency check; the beat counter alone ends the burst
  assign is_last  = (beat_cnt == LAST_BEAT);
  assign beat_bad = (rresp != 2'b00) || (rlast != is_last);
  assign err_next = err || beat_bad;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      err        <= 1'b0;
      line       <= '0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      miss_ready <= 1'b1;
      cache_wen  <= 1'b0;
      fill_done  <= 1'b0;
      fill_error <= 1'b0;
    end else if (srst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      err        <= 1'b0;
      line       <= '0;
      araddr     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      miss_ready <= 1'b1;
      cache_wen  <= 1'b0;
      fill_done  <= 1'b0;
      fill_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_valid) begin
            araddr     <= miss_addr & ~LINE_MASK;
            beat_cnt   <= '0;
            err        <= 1'b0;
            arvalid    <= 1'b1;
            miss_ready <= 1'b0;
            state      <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            line[int'(beat_cnt)*AXI_DATA_W +: AXI_DATA_W] <= rdata;
            beat_cnt <= beat_cnt + 1'b1;
            err      <= err_next;
            if (is_last) begin
              rready     <= 1'b0;
              fill_done  <= 1'b1;
              fill_error <= err_next;
              cache_wen  <= !err_next;
              state      <= WR;
            end
          end
        end
        WR: begin
          fill_done  <= 1'b0;
          fill_error <= 1'b0;
          cache_wen  <= 1'b0;
          miss_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
